// File: rtl/int_dispatch_pkg.sv
// Shared parameters and payload types for the integer dispatch slice.
package int_dispatch_pkg;

  localparam int unsigned PRF_DEPTH            = 64;
  localparam int unsigned PHY_W                = $clog2(PRF_DEPTH);
  localparam int unsigned CDB_WIDTH            = 2;
  localparam int unsigned DISPATCH_QUEUE_DEPTH = 4;
  localparam int unsigned QPTR_W               = $clog2(DISPATCH_QUEUE_DEPTH);
  localparam int unsigned QCNT_W               = QPTR_W + 1;
  localparam int unsigned OPC_W                = 8;

  typedef logic [PHY_W-1:0]     phy_t;
  typedef logic [CDB_WIDTH-1:0] cdb_vld_t;
  typedef phy_t [CDB_WIDTH-1:0] cdb_phy_t;

  // Renamed integer uop as seen by int_rs
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    phy_t             rd_phy;
    phy_t             rs1_phy;
    phy_t             rs2_phy;
    logic             rs1_valid;
    logic             rs2_valid;
  } uop_t;

  // Dispatch FIFO entry: uop plus which sources it actually reads
  typedef struct packed {
    uop_t uop;
    logic rs1_used;
    logic rs2_used;
  } q_entry_t;

  // True when any valid CDB port broadcasts the given physical register
  function automatic logic cdb_hit(input cdb_vld_t vld, input cdb_phy_t phy, input phy_t tag);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < CDB_WIDTH; i++) begin
      if (vld[i] && (phy[i] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/int_dispatch_if.sv
// Dispatch-to-int_rs handshake and CDB snoop interfaces.

// Decode-to-integer-RS uop channel
interface id_int_rs_itf;
  import int_dispatch_pkg::*;
  logic valid;
  logic ready;
  uop_t uop;
  modport dispatch (output valid, output uop, input ready);
  modport rs       (input valid, input uop, output ready);
endinterface

// Common data bus completion broadcast, all ports bundled
interface cdb_itf;
  import int_dispatch_pkg::*;
  cdb_vld_t valid;
  cdb_phy_t rd_phy;
  modport source   (output valid, output rd_phy);
  modport listener (input valid, input rd_phy);
endinterface

// File: rtl/int_dispatch_busy_table.sv
// Physical-register busy table: one set port, CDB clear ports, flush,
// and two combinational read ports returning busy state and same-cycle CDB hit.
module int_dispatch_busy_table
  import int_dispatch_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_flush,
  input  logic     i_set_en,
  input  phy_t     i_set_phy,
  input  cdb_vld_t i_clr_valid,
  input  cdb_phy_t i_clr_phy,
  input  phy_t     i_rd0_phy,
  input  phy_t     i_rd1_phy,
  output logic     o_rd0_busy_c,
  output logic     o_rd0_hit_c,
  output logic     o_rd1_busy_c,
  output logic     o_rd1_hit_c
);

  logic [PRF_DEPTH-1:0] r_busy;
  logic [PRF_DEPTH-1:0] w_busy_nxt;

  // Next table: CDB clears first, then the rename set so set wins; p0 never busy
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 0; i < CDB_WIDTH; i++) begin
      if (i_clr_valid[i]) w_busy_nxt[i_clr_phy[i]] = 1'b0;
    end
    if (i_set_en) w_busy_nxt[i_set_phy] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Table register; flush drops every pending producer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_busy <= '0;
    else if (i_flush) r_busy <= '0;
    else              r_busy <= w_busy_nxt;
  end

  assign o_rd0_busy_c = r_busy[i_rd0_phy];
  assign o_rd1_busy_c = r_busy[i_rd1_phy];
  assign o_rd0_hit_c  = cdb_hit(i_clr_valid, i_clr_phy, i_rd0_phy);
  assign o_rd1_hit_c  = cdb_hit(i_clr_valid, i_clr_phy, i_rd1_phy);

endmodule

// File: rtl/int_dispatch.sv
// Integer dispatch transmitter: buffers renamed uops, tracks register
// readiness and drives int_rs with per-source ready bits.
// Optional feature macro: DISPATCH_CDB_BYPASS_EN (same-cycle CDB wakeup
// at the FIFO head; otherwise a hazard costs a one-cycle stall).
module int_dispatch
  import int_dispatch_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_flush,
  input  logic    i_ren_valid,
  output logic    o_ren_ready,
  input  uop_t    i_ren_uop,
  input  logic    i_ren_rd_en,
  input  logic    i_ren_rs1_used,
  input  logic    i_ren_rs2_used,
  id_int_rs_itf.dispatch to_rs,
  cdb_itf.listener       cdb
);

  q_entry_t          r_mem [DISPATCH_QUEUE_DEPTH];
  logic [QPTR_W-1:0] r_head;
  logic [QPTR_W-1:0] r_tail;
  logic [QCNT_W-1:0] r_count;
  logic              r_ren_ready;

  q_entry_t          w_head;
  logic              w_accept;
  logic              w_dispatch;
  logic [QCNT_W-1:0] w_count_nxt;
  logic              w_set_en;
  logic              w_rs1_busy, w_rs1_hit, w_rs2_busy, w_rs2_hit;
  logic              w_rs1_valid, w_rs2_valid;
  logic              w_stall;

  assign w_head     = r_mem[r_head];
  assign w_accept   = i_ren_valid & r_ren_ready & ~i_flush;
  assign w_dispatch = to_rs.valid & to_rs.ready & ~i_flush;
  assign w_set_en   = w_accept & i_ren_rd_en & (i_ren_uop.rd_phy != '0);

  // Occupancy after this cycle's accept/dispatch
  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_dispatch})
      2'b10:   w_count_nxt = r_count + QCNT_W'(1);
      2'b01:   w_count_nxt = r_count - QCNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count and registered accept-ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ren_ready <= 1'b1;
    end else if (i_flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ren_ready <= 1'b1;
    end else begin
      if (w_accept)   r_tail <= r_tail + QPTR_W'(1);
      if (w_dispatch) r_head <= r_head + QPTR_W'(1);
      r_count     <= w_count_nxt;
      r_ren_ready <= (w_count_nxt != QCNT_W'(DISPATCH_QUEUE_DEPTH));
    end
  end

  // Payload storage; contents are don't-care outside the occupied window
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_tail] <= '{uop: i_ren_uop, rs1_used: i_ren_rs1_used, rs2_used: i_ren_rs2_used};
  end

  int_dispatch_busy_table u_busy (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (i_flush),
    .i_set_en     (w_set_en),
    .i_set_phy    (i_ren_uop.rd_phy),
    .i_clr_valid  (cdb.valid),
    .i_clr_phy    (cdb.rd_phy),
    .i_rd0_phy    (w_head.uop.rs1_phy),
    .i_rd1_phy    (w_head.uop.rs2_phy),
    .o_rd0_busy_c (w_rs1_busy),
    .o_rd0_hit_c  (w_rs1_hit),
    .o_rd1_busy_c (w_rs2_busy),
    .o_rd1_hit_c  (w_rs2_hit)
  );

`ifdef DISPATCH_CDB_BYPASS_EN
  // Same-cycle CDB broadcast wakes the head source directly
  assign w_rs1_valid = ~w_head.rs1_used | (w_head.uop.rs1_phy == '0) | ~w_rs1_busy | w_rs1_hit;
  assign w_rs2_valid = ~w_head.rs2_used | (w_head.uop.rs2_phy == '0) | ~w_rs2_busy | w_rs2_hit;
  assign w_stall     = 1'b0;
`else
  // Hold the head back one cycle so the cleared busy bit is seen instead
  assign w_rs1_valid = ~w_head.rs1_used | (w_head.uop.rs1_phy == '0) | ~w_rs1_busy;
  assign w_rs2_valid = ~w_head.rs2_used | (w_head.uop.rs2_phy == '0) | ~w_rs2_busy;
  assign w_stall     = (w_head.rs1_used & w_rs1_busy & w_rs1_hit) |
                       (w_head.rs2_used & w_rs2_busy & w_rs2_hit);
`endif

  // Head uop with readiness overriding the stored source-valid fields
  always_comb begin
    to_rs.uop           = w_head.uop;
    to_rs.uop.rs1_valid = w_rs1_valid;
    to_rs.uop.rs2_valid = w_rs2_valid;
  end

  assign to_rs.valid = (r_count != '0) & ~w_stall;
  assign o_ren_ready = r_ren_ready;

endmodule

// File: tb/tb_int_dispatch.sv
// Scoreboard bench for int_dispatch: stimulus pushes expected uops,
// a negedge monitor pops and compares on every dispatch handshake.
module tb_int_dispatch;
  import int_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, ren_valid, ren_ready, rd_en, u1, u2;
  uop_t ren_uop;

  id_int_rs_itf rs_if ();
  cdb_itf       cdb_if ();

  int   n_tests = 0;
  int   n_fail  = 0;
  uop_t exp_q[$];

  always #5 clk = ~clk;

  int_dispatch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (flush),
    .i_ren_valid    (ren_valid),
    .o_ren_ready    (ren_ready),
    .i_ren_uop      (ren_uop),
    .i_ren_rd_en    (rd_en),
    .i_ren_rs1_used (u1),
    .i_ren_rs2_used (u2),
    .to_rs          (rs_if),
    .cdb            (cdb_if)
  );

  function automatic uop_t mk(input int op, input int rd, input int s1, input int s2);
    uop_t u;
    u.opcode    = 8'(op);
    u.rd_phy    = phy_t'(rd);
    u.rs1_phy   = phy_t'(s1);
    u.rs2_phy   = phy_t'(s2);
    u.rs1_valid = 1'b0;
    u.rs2_valid = 1'b0;
    return u;
  endfunction

  task automatic push_exp(input uop_t u, input logic v1, input logic v2);
    uop_t e;
    e = u;
    e.rs1_valid = v1;
    e.rs2_valid = v2;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input uop_t u, input logic rde, input logic a, input logic b);
    ren_valid = 1'b1;
    ren_uop   = u;
    rd_en     = rde;
    u1        = a;
    u2        = b;
  endtask

  // Monitor: every dispatch handshake must match the oldest expectation
  always @(negedge clk) begin
    uop_t e;
    if (rst_n && rs_if.valid && rs_if.ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dispatch_unexpected: got uop %h expected no dispatch", rs_if.uop);
      end else begin
        e = exp_q.pop_front();
        chk("dispatch_uop", 64'(rs_if.uop), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    uop_t u;
    rst_n = 1'b0;
    flush = 1'b0; ren_valid = 1'b0; rd_en = 1'b0; u1 = 1'b0; u2 = 1'b0;
    ren_uop = '0;
    rs_if.ready = 1'b0;
    cdb_if.valid = '0;
    cdb_if.rd_phy = '0;

    // Reset values
    #12;
    chk("reset_valid", 64'(rs_if.valid), 64'(0));
    chk("reset_ren_ready", 64'(ren_ready), 64'(1));
    chk("reset_busy", 64'(dut.u_busy.r_busy), 64'(0));
    #5 rst_n = 1'b1;
    tick();

    // Producer A (rd p5) then consumer B (rs1 p5, rs2 p0)
    rs_if.ready = 1'b1;
    u = mk(8'h01, 5, 7, 12); offer(u, 1'b1, 1'b1, 1'b0); push_exp(u, 1'b1, 1'b1);
    tick();
    u = mk(8'h02, 6, 5, 0);  offer(u, 1'b1, 1'b1, 1'b1); push_exp(u, 1'b0, 1'b1);
    tick();
    ren_valid = 1'b0; rd_en = 1'b0;
    tick(); tick();

    // Same-cycle CDB hit on head source p5
    rs_if.ready = 1'b0;
    u = mk(8'h03, 0, 5, 20); offer(u, 1'b0, 1'b1, 1'b0); push_exp(u, 1'b1, 1'b1);
    tick();
    ren_valid = 1'b0;
    tick();
    chk("cdb_pre_valid", 64'(rs_if.valid), 64'(1));
    chk("cdb_pre_rs1_valid", 64'(rs_if.uop.rs1_valid), 64'(0));
    rs_if.ready = 1'b1;
    cdb_if.valid = 2'b10;
    cdb_if.rd_phy[1] = phy_t'(5);
    @(negedge clk);
`ifdef DISPATCH_CDB_BYPASS_EN
    chk("cdb_hit_valid", 64'(rs_if.valid), 64'(1));
`else
    chk("cdb_hit_stall_valid", 64'(rs_if.valid), 64'(0));
`endif
    tick();
    cdb_if.valid = '0;
    tick(); tick();
    chk("busy5_cleared", 64'(dut.u_busy.r_busy[5]), 64'(0));

    // Fill to full with ready held low, then drain across the wrap
    rs_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("full_ren_ready", 64'(ren_ready), 64'(i < 4));
      u = mk(8'h10 + i, 0, 0, 0); offer(u, 1'b0, 1'b1, 1'b1);
      if (i < 4) push_exp(u, 1'b1, 1'b1);
      tick();
    end
    ren_valid = 1'b0;
    rs_if.ready = 1'b1;
    chk("ren_ready_first_dispatch", 64'(ren_ready), 64'(0));
    tick();
    chk("ren_ready_after_dispatch", 64'(ren_ready), 64'(1));
    tick(); tick(); tick();
    chk("drained_valid", 64'(rs_if.valid), 64'(0));

    // Set beats clear on p9; consumer sees it busy
    u = mk(8'h20, 9, 0, 0); offer(u, 1'b1, 1'b0, 1'b0); push_exp(u, 1'b1, 1'b1);
    cdb_if.valid = 2'b01;
    cdb_if.rd_phy[0] = phy_t'(9);
    tick();
    cdb_if.valid = '0;
    chk("busy9_set_wins", 64'(dut.u_busy.r_busy[9]), 64'(1));
    u = mk(8'h21, 0, 9, 3); offer(u, 1'b0, 1'b1, 1'b1); push_exp(u, 1'b0, 1'b1);
    tick();
    ren_valid = 1'b0;
    tick(); tick();

    // Flush with three queued entries plus a same-cycle accept
    rs_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u = mk(8'h30 + i, 30 + i, 0, 0); offer(u, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("preflush_count", 64'(dut.r_count), 64'(3));
    flush = 1'b1;
    u = mk(8'h33, 33, 0, 0); offer(u, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b0; ren_valid = 1'b0; rd_en = 1'b0;
    chk("flush_count", 64'(dut.r_count), 64'(0));
    chk("flush_valid", 64'(rs_if.valid), 64'(0));
    chk("flush_ren_ready", 64'(ren_ready), 64'(1));
    chk("flush_busy", 64'(dut.u_busy.r_busy), 64'(0));
    rs_if.ready = 1'b1;
    tick(); tick();
    u = mk(8'h40, 0, 30, 33); offer(u, 1'b0, 1'b1, 1'b1); push_exp(u, 1'b1, 1'b1);
    tick();
    ren_valid = 1'b0;
    tick(); tick();

    // Mid-operation asynchronous reset
    rs_if.ready = 1'b0;
    u = mk(8'h50, 40, 0, 0); offer(u, 1'b1, 1'b0, 1'b0); tick();
    u = mk(8'h51, 41, 0, 0); offer(u, 1'b1, 1'b0, 1'b0); tick();
    ren_valid = 1'b0; rd_en = 1'b0;
    chk("prereset_valid", 64'(rs_if.valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(rs_if.valid), 64'(0));
    chk("midreset_ren_ready", 64'(ren_ready), 64'(1));
    chk("midreset_busy", 64'(dut.u_busy.r_busy), 64'(0));
    #3 rst_n = 1'b1;
    tick();
    rs_if.ready = 1'b1;
    u = mk(8'h60, 0, 40, 41); offer(u, 1'b0, 1'b1, 1'b1); push_exp(u, 1'b1, 1'b1);
    tick();
    ren_valid = 1'b0;
    tick(); tick(); tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
